// File: rtl/keypad_emulator.sv
// -----------------------------------------------------------------------------
// keypad_emulator
//
// Purpose:
//   Emulates one key of a 4x4 matrix keypad so a column-scanning keypad decoder
//   can be exercised without a physical keypad. A key code is accepted over a
//   valid/ready handshake. The emulator then closes the contact, optionally with
//   a bounce phase, holds it closed and then releases it. It reports completion
//   with a one-cycle done pulse. While the contact is closed, the key's row is
//   pulled low whenever the decoder drives that key's column low.
//
// Key map (row, col), C1..C4 from left to right:
//   R1: 1 2 3 A   R2: 4 5 6 B   R3: 7 8 9 C   R4: 0 F E D
//   Bit mapping: row[3]=R1 .. row[0]=R4, col[3]=C1 .. col[0]=C4.
//
// Ports:
//   clk        in   1  system clock
//   rst        in   1  asynchronous, active-low reset
//   key_valid  in   1  key_code is valid
//   key_code   in   4  hex key value to press
//   key_ready  out  1  high only in IDLE; a transfer happens on key_valid && key_ready
//   cancel     in   1  abort the current press (ignored in IDLE and RELEASE)
//   col        in   4  active-low column drive from the decoder
//   row        out  4  active-low row response, 4'b1111 when idle
//   pressed    out  1  current contact state (1 = closed)
//   busy       out  1  inverse of key_ready
//   done       out  1  one-cycle pulse on the first IDLE cycle after RELEASE
// -----------------------------------------------------------------------------
module keypad_emulator #(
  parameter int CNT_W          = 27,
  parameter int BOUNCE_CYCLES  = 64,
  parameter int BOUNCE_TOGGLE  = 4,
  parameter int HOLD_CYCLES    = 500000,
  parameter int RELEASE_CYCLES = 500000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       key_valid,
  input  logic [3:0] key_code,
  output logic       key_ready,
  input  logic       cancel,
  input  logic [3:0] col,
  output logic [3:0] row,
  output logic       pressed,
  output logic       busy,
  output logic       done
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BOUNCE  = 2'd1,
    HOLD    = 2'd2,
    RELEASE = 2'd3
  } state_t;

  // Terminal counter values: a phase of N cycles ends when cnt reaches N-1.
  localparam bit               HAS_BOUNCE   = (BOUNCE_CYCLES > 0);
  localparam logic [CNT_W-1:0] BOUNCE_LAST  = CNT_W'(HAS_BOUNCE ? BOUNCE_CYCLES - 1 : 0);
  localparam logic [CNT_W-1:0] TOGGLE_LAST  = CNT_W'(BOUNCE_TOGGLE - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST    = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] RELEASE_LAST = CNT_W'(RELEASE_CYCLES - 1);

  // Target of key code 0 (R4, C1); the reset value of the stored key.
  localparam logic [3:0] ROW_OF_KEY0 = 4'b0001;
  localparam logic [3:0] COL_OF_KEY0 = 4'b1000;

  state_t           state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next, cnt_inc;
  // Bounce timing: sub counts cycles within one contact level and phase
  // flips every BOUNCE_TOGGLE cycles. This gives the (cnt / BOUNCE_TOGGLE)
  // parity without needing a divider.
  logic [CNT_W-1:0] sub_reg, sub_next;
  logic             phase_reg, phase_next;
  logic [3:0]       trow_reg, trow_next;   // one-hot target row (bit3 = R1)
  logic [3:0]       tcol_reg, tcol_next;   // one-hot target column (bit3 = C1)
  logic             pressed_next;
  logic [3:0]       row_next;
  logic             done_next;

  // Decode a key code into {one-hot row, one-hot column}.
  function automatic logic [7:0] decode_key(input logic [3:0] k);
    logic [7:0] rc;
    case (k)
      4'h1:    rc = {4'b1000, 4'b1000};
      4'h2:    rc = {4'b1000, 4'b0100};
      4'h3:    rc = {4'b1000, 4'b0010};
      4'hA:    rc = {4'b1000, 4'b0001};
      4'h4:    rc = {4'b0100, 4'b1000};
      4'h5:    rc = {4'b0100, 4'b0100};
      4'h6:    rc = {4'b0100, 4'b0010};
      4'hB:    rc = {4'b0100, 4'b0001};
      4'h7:    rc = {4'b0010, 4'b1000};
      4'h8:    rc = {4'b0010, 4'b0100};
      4'h9:    rc = {4'b0010, 4'b0010};
      4'hC:    rc = {4'b0010, 4'b0001};
      4'h0:    rc = {4'b0001, 4'b1000};
      4'hF:    rc = {4'b0001, 4'b0100};
      4'hE:    rc = {4'b0001, 4'b0010};
      default: rc = {4'b0001, 4'b0001};  // 4'hD
    endcase
    return rc;
  endfunction

  // The counter saturates instead of wrapping.
  assign cnt_inc = (cnt_reg == '1) ? cnt_reg : cnt_reg + 1'b1;

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_inc;
    sub_next   = sub_reg;
    phase_next = phase_reg;
    trow_next  = trow_reg;
    tcol_next  = tcol_reg;
    done_next  = 1'b0;

    case (state_reg)
      IDLE: begin
        cnt_next = '0;
        // cancel is deliberately not looked at here: an accept always wins.
        if (key_valid) begin
          {trow_next, tcol_next} = decode_key(key_code);
          sub_next   = '0;
          phase_next = 1'b0;
          state_next = HAS_BOUNCE ? BOUNCE : HOLD;
        end
      end

      BOUNCE: begin
        if (cancel) begin
          state_next = RELEASE;
          cnt_next   = '0;
        end else if (cnt_reg == BOUNCE_LAST) begin
          state_next = HOLD;
          cnt_next   = '0;
        end else if (sub_reg == TOGGLE_LAST) begin
          sub_next   = '0;
          phase_next = ~phase_reg;
        end else begin
          sub_next = sub_reg + 1'b1;
        end
      end

      HOLD: begin
        if (cancel || (cnt_reg == HOLD_LAST)) begin
          state_next = RELEASE;
          cnt_next   = '0;
        end
      end

      default: begin  // RELEASE
        if (cnt_reg == RELEASE_LAST) begin
          state_next = IDLE;
          cnt_next   = '0;
          done_next  = 1'b1;
        end
      end
    endcase

    // The contact level is derived from the next state, so that pressed is
    // already correct on the cycle in which the new state is entered. The
    // bounce phase starts with the contact closed.
    case (state_next)
      BOUNCE:  pressed_next = ~phase_next;
      HOLD:    pressed_next = 1'b1;
      default: pressed_next = 1'b0;
    endcase

    // The row is pulled low when the target column is among the low columns
    // (wired-AND behaviour of a real matrix).
    row_next = (pressed_next && |(~col & tcol_next)) ? ~trow_next : 4'b1111;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      sub_reg   <= '0;
      phase_reg <= 1'b0;
      trow_reg  <= ROW_OF_KEY0;
      tcol_reg  <= COL_OF_KEY0;
      pressed   <= 1'b0;
      row       <= 4'b1111;
      done      <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      sub_reg   <= sub_next;
      phase_reg <= phase_next;
      trow_reg  <= trow_next;
      tcol_reg  <= tcol_next;
      pressed   <= pressed_next;
      row       <= row_next;
      done      <= done_next;
    end
  end

  assign key_ready = (state_reg == IDLE);
  assign busy      = ~key_ready;

endmodule

// File: tb/tb_keypad_emulator.sv
// -----------------------------------------------------------------------------
// tb_keypad_emulator
//
// Drives two emulator instances from the same stimulus:
//   dut_a: no bounce phase, short hold and release (map sweep, row latency)
//   dut_b: 8-cycle bounce phase toggling every 4 cycles (bounce, handshake,
//          cancel and asynchronous reset sequences)
// Inputs change on the falling clock edge. Outputs are sampled on the falling
// edge, half a cycle after the rising edge that updated them.
// -----------------------------------------------------------------------------
module tb_keypad_emulator;

  logic       clk;
  logic       rst;
  logic       key_valid;
  logic [3:0] key_code;
  logic       cancel;
  logic [3:0] col;

  logic       a_key_ready, a_pressed, a_busy, a_done;
  logic [3:0] a_row;
  logic       b_key_ready, b_pressed, b_busy, b_done;
  logic [3:0] b_row;

  int n_checks = 0;
  int n_fail   = 0;

  keypad_emulator #(
    .CNT_W(8), .BOUNCE_CYCLES(0), .BOUNCE_TOGGLE(4),
    .HOLD_CYCLES(20), .RELEASE_CYCLES(6)
  ) dut_a (
    .clk(clk), .rst(rst), .key_valid(key_valid), .key_code(key_code),
    .key_ready(a_key_ready), .cancel(cancel), .col(col), .row(a_row),
    .pressed(a_pressed), .busy(a_busy), .done(a_done)
  );

  keypad_emulator #(
    .CNT_W(8), .BOUNCE_CYCLES(8), .BOUNCE_TOGGLE(4),
    .HOLD_CYCLES(20), .RELEASE_CYCLES(6)
  ) dut_b (
    .clk(clk), .rst(rst), .key_valid(key_valid), .key_code(key_code),
    .key_ready(b_key_ready), .cancel(cancel), .col(col), .row(b_row),
    .pressed(b_pressed), .busy(b_busy), .done(b_done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got time limit reached, expected test completion");
    $fatal(1, "watchdog");
  end

  typedef struct packed {
    logic [3:0] key;
    logic [3:0] col;   // active-low column where the key is wired
    logic [3:0] row;   // expected active-low row response
  } vec_t;

  vec_t       vecs [16];
  logic [3:0] scan [4];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_both_idle();
    int k;
    k = 0;
    while (!(a_key_ready && b_key_ready) && k < 300) begin
      @(negedge clk);
      k++;
    end
    check("wait_idle", {30'd0, a_key_ready, b_key_ready}, 32'd3);
  endtask

  // Present a key for one cycle; returns after the accepting rising edge.
  task automatic press(input logic [3:0] k);
    key_code  = k;
    key_valid = 1'b1;
    @(negedge clk);
    key_valid = 1'b0;
  endtask

  int   busy_cnt;
  int   done_cnt;
  logic exp_p;

  initial begin
    // Hand-computed key map: {key, active-low column, active-low row}.
    vecs[0]  = '{4'h0, 4'b0111, 4'b1110};
    vecs[1]  = '{4'h1, 4'b0111, 4'b0111};
    vecs[2]  = '{4'h2, 4'b1011, 4'b0111};
    vecs[3]  = '{4'h3, 4'b1101, 4'b0111};
    vecs[4]  = '{4'h4, 4'b0111, 4'b1011};
    vecs[5]  = '{4'h5, 4'b1011, 4'b1011};
    vecs[6]  = '{4'h6, 4'b1101, 4'b1011};
    vecs[7]  = '{4'h7, 4'b0111, 4'b1101};
    vecs[8]  = '{4'h8, 4'b1011, 4'b1101};
    vecs[9]  = '{4'h9, 4'b1101, 4'b1101};
    vecs[10] = '{4'hA, 4'b1110, 4'b0111};
    vecs[11] = '{4'hB, 4'b1110, 4'b1011};
    vecs[12] = '{4'hC, 4'b1110, 4'b1101};
    vecs[13] = '{4'hD, 4'b1110, 4'b1110};
    vecs[14] = '{4'hE, 4'b1101, 4'b1110};
    vecs[15] = '{4'hF, 4'b1011, 4'b1110};
    scan[0] = 4'b0111;
    scan[1] = 4'b1011;
    scan[2] = 4'b1101;
    scan[3] = 4'b1110;

    key_valid = 1'b0;
    key_code  = 4'h0;
    cancel    = 1'b0;
    col       = 4'b1111;
    rst       = 1'b1;
    #2 rst = 1'b0;
    #1;
    // Reset state, before any clock edge.
    check("reset_row_a",   a_row, 4'b1111);
    check("reset_press_a", a_pressed, 1'b0);
    check("reset_ready_a", a_key_ready, 1'b1);
    check("reset_busy_a",  a_busy, 1'b0);
    check("reset_done_a",  a_done, 1'b0);
    check("reset_row_b",   b_row, 4'b1111);
    check("reset_ready_b", b_key_ready, 1'b1);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("post_reset_ready_b", b_key_ready, 1'b1);

    // Row latency from col with key 0x5 (no bounce phase).
    press(4'h5);
    check("k5_ready", a_key_ready, 1'b0);
    check("k5_press", a_pressed, 1'b1);
    col = 4'b1011;
    #1 check("k5_row_latency", a_row, 4'b1111);
    @(negedge clk);
    check("k5_row_c2", a_row, 4'b1011);
    col = 4'b0111;
    @(negedge clk);
    check("k5_row_c1", a_row, 4'b1111);
    col = 4'b0011;
    @(negedge clk);
    check("k5_row_multi", a_row, 4'b1011);
    col = 4'b1111;
    @(negedge clk);
    check("k5_row_undriven", a_row, 4'b1111);
    wait_both_idle();

    // Full key map sweep on dut_a.
    for (int v = 0; v < 16; v++) begin
      press(vecs[v].key);
      $display("key %h accepted, mapped col %b row %b", vecs[v].key, vecs[v].col, vecs[v].row);
      check("sweep_press", a_pressed, 1'b1);
      for (int c = 0; c < 4; c++) begin
        col = scan[c];
        @(negedge clk);
        check("sweep_row", {vecs[v].key, scan[c], a_row},
              {vecs[v].key, scan[c], (scan[c] == vecs[v].col) ? vecs[v].row : 4'b1111});
      end
      col = 4'b0000;
      @(negedge clk);
      check("sweep_all_cols", a_row, vecs[v].row);
      col = 4'b1111;
      wait_both_idle();
    end

    // Bounce profile on dut_b: key 0x1 at column C1.
    col       = 4'b0111;
    key_code  = 4'h1;
    key_valid = 1'b1;
    for (int i = 0; i <= 28; i++) begin
      @(negedge clk);
      if (i == 0) key_valid = 1'b0;
      exp_p = (i < 4) ? 1'b1 : (i < 8) ? 1'b0 : (i < 28) ? 1'b1 : 1'b0;
      check("bounce_pressed", {i[7:0], 7'd0, b_pressed}, {i[7:0], 7'd0, exp_p});
      check("bounce_row", {i[7:0], b_row}, {i[7:0], exp_p ? 4'b0111 : 4'b1111});
    end
    $display("bounce press of key 1 finished");
    wait_both_idle();

    // Handshake: key_valid held high across a whole press.
    key_code  = 4'h2;
    key_valid = 1'b1;
    busy_cnt  = 0;
    done_cnt  = 0;
    for (int i = 0; i <= 35; i++) begin
      @(negedge clk);
      if (i <= 34 && !b_key_ready) busy_cnt++;
      if (b_done) done_cnt++;
      if (i == 34) begin
        check("hs_ready_at_done", b_key_ready, 1'b1);
        check("hs_done_at_idle", b_done, 1'b1);
      end
      if (i == 35) check("hs_reaccept", b_key_ready, 1'b0);
    end
    key_valid = 1'b0;
    check("hs_busy_cycles", busy_cnt, 34);
    check("hs_done_count", done_cnt, 1);
    $display("handshake press of key 2 finished");
    wait_both_idle();

    // Cancel at HOLD cycle 5 on dut_b.
    col = 4'b0111;
    press(4'h1);
    repeat (13) @(negedge clk);
    check("cancel_pre_pressed", b_pressed, 1'b1);
    check("cancel_pre_row", b_row, 4'b0111);
    cancel = 1'b1;
    @(negedge clk);
    cancel = 1'b0;
    check("cancel_pressed", b_pressed, 1'b0);
    check("cancel_row", b_row, 4'b1111);
    check("cancel_busy", b_key_ready, 1'b0);
    for (int i = 1; i <= 6; i++) begin
      @(negedge clk);
      check("cancel_done", {i[7:0], 7'd0, b_done}, {i[7:0], 7'd0, (i == 6)});
      check("cancel_release_pressed", b_pressed, 1'b0);
    end

    // cancel together with key_valid in IDLE: the key is still accepted.
    cancel    = 1'b1;
    key_code  = 4'h1;
    key_valid = 1'b1;
    @(negedge clk);
    cancel    = 1'b0;
    key_valid = 1'b0;
    check("idle_cancel_accept", b_key_ready, 1'b0);
    check("idle_cancel_pressed", b_pressed, 1'b1);
    @(negedge clk);
    check("idle_cancel_still_pressed", b_pressed, 1'b1);
    check("idle_cancel_busy", b_busy, 1'b1);
    $display("cancel sequence finished");
    wait_both_idle();

    // Asynchronous reset in the middle of HOLD on dut_b.
    col = 4'b0111;
    press(4'h1);
    repeat (12) @(negedge clk);
    check("rst_mid_pressed", b_pressed, 1'b1);
    #2 rst = 1'b0;
    #1;
    check("rst_mid_row", b_row, 4'b1111);
    check("rst_mid_press", b_pressed, 1'b0);
    check("rst_mid_ready", b_key_ready, 1'b1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("rst_after_ready", b_key_ready, 1'b1);
    check("rst_after_press", b_pressed, 1'b0);
    check("rst_after_row", b_row, 4'b1111);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
